mac_col_kd: RTL and testbench

//  Parametrised attention MAC column: holds KD key chunks (PR*BW each) for its column, streams

---
 rtl/mac_pkg.sv | 8 +
 rtl/mac_col_kd_if.sv | 12 +
 rtl/mac_dot.sv | 15 +
 rtl/mac_col_kd.sv | 87 ++++++++
 tb/tb_mac_col_kd.sv | 135 +++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: instruction encoding shared by the MAC array columns
package mac_pkg;
  localparam int INST_W = 3;
  localparam int INST_LOAD = 0;
  localparam int INST_EXEC = 1;
  localparam int INST_FLUSH = 2;
  typedef logic [INST_W-1:0] inst_t;
endpackage

// File: rtl/mac_col_kd_if.sv
// mac_col_kd_if: column-to-column query/instruction link plus psum result port
interface mac_col_kd_if #(parameter int BW = 8, parameter int PR = 8, parameter int BW_PSUM = 2*BW+6);
  import mac_pkg::*;
  inst_t i_inst;
  inst_t o_inst;
  logic [PR*BW-1:0] q_in;
  logic [PR*BW-1:0] q_out;
  logic [BW_PSUM-1:0] out;
  logic fifo_wr;
  modport master(output i_inst, q_in, input o_inst, q_out, out, fifo_wr);
  modport slave(input i_inst, q_in, output o_inst, q_out, out, fifo_wr);
endinterface

// File: rtl/mac_dot.sv
// mac_dot: PR-lane signed dot product, sign-extended and summed modulo 2^OW
module mac_dot #(parameter int BW = 8, parameter int PR = 8, parameter int OW = 2*BW+6) (
  input  logic [PR*BW-1:0] a,
  input  logic [PR*BW-1:0] b,
  output logic [OW-1:0]    y
);
  logic signed [2*BW-1:0] p [PR];
  always_comb begin
    y = '0;
    for (int i = 0; i < PR; i++) begin
      p[i] = $signed(a[i*BW +: BW]) * $signed(b[i*BW +: BW]);
      y = y + {{(OW-2*BW){p[i][2*BW-1]}}, p[i]};
    end
  end
endmodule

// File: rtl/mac_col_kd.sv
// mac_col_kd: attention MAC column holding KD key chunks, accumulating chunk dot-products per query row
module mac_col_kd import mac_pkg::*; #(
  parameter int BW = 8,
  parameter int PR = 8,
  parameter int KD = 2,
  parameter int COL = 8,
  parameter int BW_PSUM = 2*BW+6,
  localparam int CW = COL > 1 ? $clog2(COL) : 1
) (
  input logic clk,
  input logic reset,
  input logic [CW-1:0] col_id,
  mac_col_kd_if.slave bus
);
  localparam int PW = KD > 1 ? $clog2(KD) : 1;
  localparam int NW = $clog2(COL*KD+1) + 1;
  inst_t inst_q;
  logic prev_ld, load_ready, v1, v2, last2;
  logic [NW-1:0] cnt, b, base;
  logic [PR*BW-1:0] query_q;
  logic [PR*BW-1:0] keys [KD];
  logic [PW-1:0] ptr, sel, kidx;
  logic [BW_PSUM-1:0] prod_q, acc, dot;
  logic ld, fl, ex, act, own, last_own;
  always_comb begin
    ld = inst_q[INST_LOAD];
    fl = inst_q[INST_FLUSH];
    ex = inst_q[INST_EXEC] && !ld && !fl;
    act = ld && (!prev_ld || load_ready);
    b = (ld && !prev_ld) ? '0 : cnt;
    base = NW'(col_id) * NW'(KD);
    own = act && b >= base && b < base + NW'(KD);
    last_own = b == base + NW'(KD-1);
    kidx = PW'(b - base);
  end
  mac_dot #(.BW(BW), .PR(PR), .OW(BW_PSUM)) u_dot (.a(query_q), .b(keys[sel]), .y(dot));
  assign bus.o_inst = inst_q;
  assign bus.q_out = query_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q <= '0;
      prev_ld <= 1'b0;
      load_ready <= 1'b1;
      cnt <= '0;
      query_q <= '0;
      for (int i = 0; i < KD; i++) keys[i] <= '0;
      ptr <= '0;
      sel <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      last2 <= 1'b0;
      prod_q <= '0;
      acc <= '0;
      bus.out <= '0;
      bus.fifo_wr <= 1'b0;
    end else begin
      inst_q <= bus.i_inst;
      prev_ld <= ld;
      bus.fifo_wr <= 1'b0;
      if (ld || ex) query_q <= bus.q_in;
      if (act) begin
        cnt <= b + NW'(1);
        load_ready <= !last_own;
      end
      if (own) keys[kidx] <= bus.q_in;
      v1 <= ex;
      if (ex) begin
        sel <= ptr;
        ptr <= ptr == PW'(KD-1) ? '0 : ptr + PW'(1);
      end
      v2 <= v1 && !fl;
      prod_q <= dot;
      last2 <= sel == PW'(KD-1);
      // a flush also swallows the stage-3 result so the aborted row never pulses fifo_wr
      if (fl) begin
        ptr <= '0;
        acc <= '0;
      end else if (v2) begin
        if (last2) begin
          bus.out <= acc + prod_q;
          bus.fifo_wr <= 1'b1;
          acc <= '0;
        end else acc <= acc + prod_q;
      end
    end
  end
endmodule

// File: tb/tb_mac_col_kd.sv
// tb_mac_col_kd: table-driven check of mac_col_kd (KD=2, col_id=1) plus flush/reset/load-exec corner sequences
module tb_mac_col_kd;
  localparam int BW = 8, PR = 8, KD = 2, COL = 8, BW_PSUM = 22;
  localparam logic [2:0] LD = 3'b001, EX = 3'b010, FL = 3'b100;
  typedef struct { int k0; int k1; int q0; int q1; longint e; } vec_t;
  logic clk = 0, reset = 1;
  logic [PR*BW-1:0] pend = '0;
  logic [BW_PSUM-1:0] last_out = '0;
  int cyc = 0, wr_cnt = 0, wr_cyc = 0, cmp = 0, err = 0, w0, start;
  vec_t tbl [6];
  mac_col_kd_if #(.BW(BW), .PR(PR), .BW_PSUM(BW_PSUM)) bus ();
  mac_col_kd #(.BW(BW), .PR(PR), .KD(KD), .COL(COL), .BW_PSUM(BW_PSUM)) dut (
    .clk(clk), .reset(reset), .col_id(3'd1), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [PR*BW-1:0] lanes(input int v);
    for (int i = 0; i < PR; i++) lanes[i*BW +: BW] = v[BW-1:0];
  endfunction
  function automatic logic [PR*BW-1:0] ramp(input int off);
    for (int i = 0; i < PR; i++) ramp[i*BW +: BW] = BW'(i + off);
  endfunction
  task automatic chk(input string n, input longint a, input longint e);
    cmp++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  // data trails its instruction by one cycle, matching the upstream column's skew
  task automatic beat(input logic [2:0] inst, input logic [PR*BW-1:0] d);
    bus.i_inst = inst;
    bus.q_in = pend;
    pend = d;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.fifo_wr) begin
      wr_cnt++;
      last_out = bus.out;
      wr_cyc = cyc;
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(3'b000, '0);
  endtask
  task automatic load_keys(input logic [PR*BW-1:0] k0, input logic [PR*BW-1:0] k1);
    beat(LD, lanes(9));
    beat(LD, lanes(9));
    beat(LD, k0);
    beat(LD, k1);
    beat(LD, lanes(77));
    idle(2);
  endtask
  initial begin
    tbl = '{'{3, 4, 1, 1, 56}, '{1, 1, 2, 2, 32}, '{-128, -128, -128, -128, 262144},
            '{3, -2, 5, 7, 8}, '{127, 127, -128, -128, -260096}, '{-1, 1, 1, -1, -16}};
    bus.i_inst = '0;
    bus.q_in = '0;
    idle(3);
    chk("rst_o_inst", bus.o_inst, 0);
    chk("rst_q_out", bus.q_out, 0);
    chk("rst_out", bus.out, 0);
    chk("rst_fifo_wr", bus.fifo_wr, 0);
    reset = 0;
    idle(1);
    beat(LD, lanes(5));
    chk("o_inst_fwd", bus.o_inst, LD);
    idle(1);
    chk("q_out_fwd", bus.q_out, lanes(5));
    idle(2);
    foreach (tbl[v]) begin
      w0 = wr_cnt;
      load_keys(lanes(tbl[v].k0), lanes(tbl[v].k1));
      chk($sformatf("v%0d_load_no_wr", v), wr_cnt - w0, 0);
      beat(EX, lanes(tbl[v].q0));
      beat(EX, lanes(tbl[v].q1));
      start = cyc;
      idle(5);
      chk($sformatf("v%0d_wr_cnt", v), wr_cnt - w0, 1);
      chk($sformatf("v%0d_latency", v), wr_cyc - start, 3);
      chk($sformatf("v%0d_out", v), longint'($signed(last_out)), tbl[v].e);
    end
    load_keys(ramp(1), lanes(0));
    w0 = wr_cnt;
    beat(EX, ramp(0));
    beat(EX, lanes(5));
    idle(5);
    chk("ramp_out", longint'($signed(last_out)), 168);
    chk("ramp_wr", wr_cnt - w0, 1);
    load_keys(lanes(1), lanes(1));
    w0 = wr_cnt;
    beat(EX, lanes(7));
    beat(FL, '0);
    beat(EX, lanes(1));
    beat(EX, lanes(1));
    idle(5);
    chk("flush_out", longint'($signed(last_out)), 16);
    chk("flush_wr", wr_cnt - w0, 1);
    w0 = wr_cnt;
    beat(EX, lanes(3));
    beat(FL | EX, lanes(3));
    beat(EX, lanes(1));
    beat(EX, lanes(1));
    idle(5);
    chk("flush_ex_out", longint'($signed(last_out)), 16);
    chk("flush_ex_wr", wr_cnt - w0, 1);
    w0 = wr_cnt;
    beat(EX, lanes(2));
    beat(LD | EX, lanes(50));
    idle(1);
    chk("ld_ex_no_wr", wr_cnt - w0, 0);
    beat(EX, lanes(3));
    idle(5);
    chk("ld_ex_out", longint'($signed(last_out)), 40);
    chk("ld_ex_wr", wr_cnt - w0, 1);
    load_keys(lanes(1), lanes(1));
    w0 = wr_cnt;
    beat(EX, lanes(1));
    beat(EX, lanes(1));
    idle(2);
    reset = 1;
    idle(2);
    reset = 0;
    idle(4);
    chk("rst_mid_no_wr", wr_cnt - w0, 0);
    chk("rst_mid_out", bus.out, 0);
    w0 = wr_cnt;
    beat(EX, lanes(1));
    beat(EX, lanes(1));
    idle(5);
    chk("rst_keys_wr", wr_cnt - w0, 1);
    chk("rst_keys_out", longint'($signed(last_out)), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
